// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: assembles big-endian words from a host byte
// stream, writes them to IM from address 0, verifies an XOR checksum, then releases the core.
module im_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              WE,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [31:0]       W_Ins,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // One word past the last IM address is still a legal count (fills IM exactly).
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        bidx;
  logic [23:0]       shift;
  logic [31:0]       word_in;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   n_words;
  logic [31:0]       acc;
  logic [31:0]       acc_nxt;
  logic              take;
  logic              last_byte;
  logic              session_start;

  function automatic logic accepts_bytes(input state_t s);
    return (s == S_HDR) || (s == S_DATA) || (s == S_CHK);
  endfunction

  function automatic logic in_session(input state_t s);
    return (s == S_HDR) || (s == S_DATA) || (s == S_WRITE) || (s == S_CHK);
  endfunction

  function automatic logic [31:0] xor_fold(input logic [31:0] a, input logic [31:0] b);
    return a ^ b;
  endfunction

  // Byte handshake decode and next-state selection.
  always_comb begin
    take          = rx_valid && rx_ready;
    last_byte     = take && (bidx == 2'd3);
    word_in       = {shift, rx_data};
    cnt_inc       = cnt + {{ADDR_W{1'b0}}, 1'b1};
    acc_nxt       = xor_fold(acc, W_Ins);
    state_nxt     = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR;
        else       state_nxt = S_IDLE;
      end
      S_HDR: begin
        if (!last_byte)                       state_nxt = S_HDR;
        else if ({1'b0, word_in} > MAX_WORDS) state_nxt = S_ERR;
        else if (word_in == 32'd0)            state_nxt = S_CHK;
        else                                  state_nxt = S_DATA;
      end
      S_DATA: begin
        if (last_byte) state_nxt = S_WRITE;
        else           state_nxt = S_DATA;
      end
      S_WRITE: begin
        if (cnt_inc == n_words) state_nxt = S_CHK;
        else                    state_nxt = S_DATA;
      end
      S_CHK: begin
        if (!last_byte)          state_nxt = S_CHK;
        else if (word_in == acc) state_nxt = S_DONE;
        else                     state_nxt = S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start) state_nxt = S_HDR;
        else       state_nxt = state;
      end
      default: state_nxt = S_IDLE;
    endcase
    session_start = (state_nxt == S_HDR) && !in_session(state);
  end

  // State, registered outputs and the byte/word datapath.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      rx_ready <= 1'b0;
      WE       <= 1'b0;
      W_Addr   <= {ADDR_W{1'b0}};
      W_Ins    <= 32'd0;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bidx     <= 2'd0;
      shift    <= 24'd0;
      cnt      <= {(ADDR_W+1){1'b0}};
      n_words  <= {(ADDR_W+1){1'b0}};
      acc      <= 32'd0;
    end else begin
      state    <= state_nxt;
      rx_ready <= accepts_bytes(state_nxt);
      busy     <= in_session(state_nxt);
      WE       <= (state_nxt == S_WRITE);
      done     <= (state_nxt == S_DONE);
      err      <= (state_nxt == S_ERR);
      core_rst <= (state_nxt != S_DONE);

      if (session_start) begin
        bidx <= 2'd0;
        cnt  <= {(ADDR_W+1){1'b0}};
        acc  <= 32'd0;
      end else if (state == S_WRITE) begin
        acc <= acc_nxt;
        cnt <= cnt_inc;
      end else if (take) begin
        bidx  <= bidx + 2'd1;
        shift <= word_in[23:0];
      end else begin
        bidx <= bidx;
      end

      // Only the low ADDR_W+1 bits matter once the count has passed the range check.
      if (state == S_HDR && last_byte) begin
        n_words <= word_in[ADDR_W:0];
      end else begin
        n_words <= n_words;
      end

      if (state == S_DATA && last_byte) begin
        W_Ins  <= word_in;
        W_Addr <= cnt[ADDR_W-1:0];
      end else begin
        W_Ins  <= W_Ins;
        W_Addr <= W_Addr;
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: expected IM writes and session outcomes are queued by the
// stimulus and checked by an independent monitor as the loader presents them.
module tb_im_loader;

  localparam int ADDR_W = 8;

  logic              CLK;
  logic              RST;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              WE;
  logic [ADDR_W-1:0] W_Addr;
  logic [31:0]       W_Ins;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W+31:0] wr_q[$];
  logic [1:0]         out_q[$];

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .WE(WE), .W_Addr(W_Addr), .W_Ins(W_Ins),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every write pulse and every session outcome against the queues.
  logic prev_we = 1'b0;
  logic prev_fin = 1'b0;
  always @(negedge CLK) begin
    if (WE) begin
      check("we_single_cycle", {63'd0, prev_we}, 64'd0);
      check("rx_ready_in_write", {63'd0, rx_ready}, 64'd0);
      if (wr_q.size() == 0) begin
        check("unexpected_write", {W_Addr, W_Ins}, 64'd0 - 64'd1);
      end else begin
        logic [ADDR_W+31:0] e;
        e = wr_q.pop_front();
        check("write_addr", {56'd0, W_Addr}, {56'd0, e[ADDR_W+31:32]});
        check("write_ins", {32'd0, W_Ins}, {32'd0, e[31:0]});
      end
    end
    if ((done || err) && !prev_fin) begin
      if (out_q.size() == 0) begin
        check("unexpected_outcome", {62'd0, done, err}, 64'd0);
      end else begin
        logic [1:0] o;
        o = out_q.pop_front();
        check("outcome_done_err", {62'd0, done, err}, {62'd0, o});
        check("outcome_core_rst", {63'd0, core_rst}, {63'd0, ~o[1]});
        check("outcome_busy", {63'd0, busy}, 64'd0);
      end
    end
    prev_we  = WE;
    prev_fin = done || err;
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check("rx_ready_timeout", 64'd0, 64'd1);
    @(posedge CLK);
    #1 rx_valid = 1'b0;
    if (gap) @(posedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic do_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("core_rst_in_session", {63'd0, core_rst}, 64'd1);
    check("done_cleared", {62'd0, done, err}, 64'd0);
  endtask

  task automatic settle();
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd0);
    check({tag, "_we"}, {63'd0, WE}, 64'd0);
    check({tag, "_w_addr"}, {56'd0, W_Addr}, 64'd0);
    check({tag, "_w_ins"}, {32'd0, W_Ins}, 64'd0);
    check({tag, "_core_rst"}, {63'd0, core_rst}, 64'd1);
    check({tag, "_busy_done_err"}, {61'd0, busy, done, err}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; start = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    RST = 1'b0;
    settle();
    check_reset_vals("idle");

    // Normal load, N=2
    do_start();
    wr_q.push_back({8'd0, 32'h20080005});
    wr_q.push_back({8'd1, 32'h2009000A});
    out_q.push_back(2'b10);
    send_word(32'd2, 1'b0);
    send_word(32'h20080005, 1'b0);
    send_word(32'h2009000A, 1'b0);
    send_word(32'h0001000F, 1'b0);
    settle();
    check("hold_w_addr", {56'd0, W_Addr}, 64'd1);
    check("hold_w_ins", {32'd0, W_Ins}, 64'h2009000A);
    check("done_core_released", {62'd0, done, core_rst}, 64'b10);

    // Bad checksum
    do_start();
    wr_q.push_back({8'd0, 32'h20080005});
    wr_q.push_back({8'd1, 32'h2009000A});
    out_q.push_back(2'b01);
    send_word(32'd2, 1'b0);
    send_word(32'h20080005, 1'b0);
    send_word(32'h2009000A, 1'b0);
    send_word(32'h00000000, 1'b0);
    settle();

    // Empty image
    do_start();
    out_q.push_back(2'b10);
    send_word(32'd0, 1'b0);
    send_word(32'd0, 1'b0);
    settle();

    // Oversize count: err and rx_ready drop in the cycle after the 4th header byte
    do_start();
    out_q.push_back(2'b01);
    send_word(32'h00000101, 1'b0);
    @(negedge CLK);
    check("oversize_err", {63'd0, err}, 64'd1);
    check("oversize_rx_ready", {63'd0, rx_ready}, 64'd0);
    settle();

    // Maximum legal count fills the whole IM; XOR of 0..255 is 0
    do_start();
    for (int i = 0; i < 256; i++) wr_q.push_back({i[7:0], 32'hA5000000 | i});
    out_q.push_back(2'b10);
    send_word(32'd256, 1'b0);
    for (int i = 0; i < 256; i++) send_word(32'hA5000000 | i, 1'b0);
    send_word(32'd0, 1'b0);
    settle();

    // Gapped stream; first checksum byte is offered during the write cycle
    do_start();
    wr_q.push_back({8'd0, 32'h8C010004});
    out_q.push_back(2'b10);
    send_word(32'd1, 1'b1);
    send_word(32'h8C010004, 1'b1);
    send_word(32'h8C010004, 1'b0);
    settle();

    // Reset mid-session after 1 of 3 words
    do_start();
    wr_q.push_back({8'd0, 32'h11111111});
    send_word(32'd3, 1'b0);
    send_word(32'h11111111, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    #1 check_reset_vals("mid_rst");
    @(negedge CLK);
    RST = 1'b0;
    settle();
    check("after_rst_idle_busy", {63'd0, busy}, 64'd0);

    // start while busy is ignored (pulsed mid-word)
    do_start();
    wr_q.push_back({8'd0, 32'h12345678});
    out_q.push_back(2'b10);
    send_word(32'd1, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    send_word(32'h12345678, 1'b0);
    settle();

    // Restart from DONE: core_rst reasserts until the new load completes
    do_start();
    wr_q.push_back({8'd0, 32'hDEADBEEF});
    out_q.push_back(2'b10);
    send_word(32'd1, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    check("reload_core_rst_held", {63'd0, core_rst}, 64'd1);
    send_word(32'hDEADBEEF, 1'b0);
    settle();
    check("reload_core_released", {63'd0, core_rst}, 64'd0);

    check("writes_all_seen", wr_q.size(), 64'd0);
    check("outcomes_all_seen", out_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time instruction-memory writer: the producing end of the IM write port (WE/W_Ins) that the fetch stage's instruction memory consumes. It accepts a byte stream from a host link, assembles big-endian 32-bit instruction words, writes them to consecutive IM word addresses starting at 0, and checks an XOR checksum. The processor core is held in reset until a load completes cleanly. It sits between the host byte interface and the IM write port.

## Interface

- ADDR_W, 8, IM word-address width; IM depth is 2^ADDR_W words.

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to begin a load session
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- WE  out  1  IM write enable, one-cycle pulse per word
- W_Addr  out  ADDR_W  IM word address for the current write
- W_Ins  out  32  instruction word to write
- core_rst  out  1  hold-reset to the core; high until a clean load finishes
- busy  out  1  load session in progress
- done  out  1  last session completed with good checksum
- err  out  1  last session failed (oversize count or checksum mismatch)

## Operation

- A byte is accepted on a rising edge with rx_valid && rx_ready; bytes assemble MSB first (first byte -> bits 31:24).
- Stream format: 4-byte word count N, then N instruction words (4 bytes each), then 4-byte checksum = XOR of all N words (0 when N = 0).
- States: IDLE, HDR, DATA, WRITE, CHK, DONE, ERR.
- IDLE: rx_ready=0, busy=0. start -> HDR, clear byte index, word counter, XOR accumulator, done, err; core_rst=1.
- HDR: rx_ready=1. After the 4th byte: N > 2^ADDR_W -> ERR; N = 0 -> CHK; otherwise -> DATA.
- DATA: rx_ready=1. After the 4th byte of a word -> WRITE.
- WRITE: rx_ready=0, WE=1, W_Ins = assembled word, W_Addr = word counter (low ADDR_W bits). The accumulator XORs in the word and the counter increments. If the counter now equals N -> CHK, else -> DATA.
- CHK: rx_ready=1. After the 4th byte: value equals accumulator -> DONE, else -> ERR.
- DONE: done=1, core_rst=0, busy=0, rx_ready=0. start -> HDR (core_rst reasserts, done clears).
- ERR: err=1, core_rst=1, busy=0, rx_ready=0. start -> HDR (err clears).
- busy=1 in HDR, DATA, WRITE, CHK. start is ignored while busy.
- The word counter is ADDR_W+1 bits wide, so N = 2^ADDR_W is legal and fills the IM exactly.
- No timeout. rx_valid gaps hold the byte index and state indefinitely.
- W_Addr and W_Ins hold their last values when WE=0.

## Timing

- Reset values: rx_ready 0, WE 0, W_Addr 0, W_Ins 0, core_rst 1, busy 0, done 0, err 0, state IDLE.
- RST mid-session forces reset values immediately (asynchronous). Words already written stay in IM. A new start is required.
- WE pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted. Minimum 5 cycles per word with rx_valid held high.
- busy rises in the cycle after start is sampled.
- done/err and the core_rst release occur in the cycle after the final checksum byte is accepted. err for an oversize count occurs in the cycle after the 4th header byte.
- start sampled in the same cycle as DONE/ERR entry is ignored; it is honoured from the following cycle.

## Test plan

- Normal load, N=2: bytes 00 00 00 02, 20 08 00 05, 20 09 00 0A, 00 01 00 0F -> WE pulses at W_Addr 0 (W_Ins 0x20080005) and W_Addr 1 (W_Ins 0x2009000A), then done=1, core_rst=0, err=0.
- Bad checksum: same stream with checksum 00 00 00 00 -> two WE pulses, then err=1, done=0, core_rst=1.
- Empty image: 00 00 00 00, 00 00 00 00 -> no WE pulse, done=1, core_rst=0.
- Oversize count (ADDR_W=8): 00 00 01 01 -> err=1 one cycle after the 4th byte, rx_ready=0, no WE.
- Backpressure and gaps: N=1 word 0x8C010004 with rx_valid toggling every other cycle -> single WE with correct data. rx_ready=0 during the WRITE cycle, and a byte offered there is not consumed.
- Reset and restart: RST asserted after 1 of 3 words -> all outputs at reset values within the same cycle. start while busy is ignored. start from DONE reloads and core_rst re-asserts until the new load completes.
